// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared opcode/funct constants and the hazard-controller state
//             encoding for the 5-stage pipelined CPU.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;

  // Width of the multiply busy counter; holds latencies up to 7.
  localparam int MCNT_W = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOADING  = 2'd1,
    MUL_WAIT = 2'd2
  } stall_state_t;

endpackage
`default_nettype wire

// File: rtl/mul_busy_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mul_busy_counter
//  Purpose  : Tracks how many more cycles Hi/Lo are owned by an in-flight
//             multiply. Loads MUL_LATENCY on issue, counts down to zero and
//             holds there (never wraps).
//  Ports    : clk   - clock, rising edge
//             rst   - asynchronous, active-high clear
//             clear - synchronous clear (instruction-load mode)
//             load  - multiply issues this cycle
//             mcnt  - current count
//             busy  - count is nonzero
//  Revision : 1.0  initial release
// ============================================================================
module mul_busy_counter
  import cpu_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  output logic [MCNT_W-1:0] mcnt,
  output logic              busy
);

  logic [MCNT_W-1:0] mcnt_d;
  logic [MCNT_W-1:0] mcnt_q;

  // clear wins over load: a load request can only arrive on a non-stalled
  // cycle, and instruction-load mode always stalls, so they never coincide.
  always_comb begin
    mcnt_d = mcnt_q;
    if (clear) begin
      mcnt_d = '0;
    end else if (load) begin
      mcnt_d = MCNT_W'(MUL_LATENCY);
    end else if (mcnt_q != '0) begin
      mcnt_d = mcnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt_q <= '0;
    end else begin
      mcnt_q <= mcnt_d;
    end
  end

  assign mcnt = mcnt_q;
  assign busy = (mcnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_stall_ctrl
//  Purpose  : ID-stage hazard/stall controller. Stalls the front end for
//             instruction-load mode, load-use hazards and Hi/Lo multiply
//             interlocks, and flushes IF/ID on taken branches that advance.
//  Config   : MUL_INTERLOCK_EN - when defined, the multiply busy counter,
//             MUL_WAIT state and Hi/Lo interlock are built; otherwise the
//             multiply is treated as single-cycle and MulBusy is tied low.
//  Ports    : clk, Reset (async, active-high)
//             LoadInstructions, IFID_OpCode/Funct/Rs/Rt  - ID-stage inputs
//             IDEX_MemRead, IDEX_Rt                       - EX-stage load info
//             BranchTaken                                 - ID branch resolved
//             PCWrite, IFID_Enable, HazardMuxSelect,
//             IF_Flush, MulBusy                           - control outputs
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       LoadInstructions,
  input  logic [5:0] IFID_OpCode,
  input  logic [5:0] IFID_Funct,
  input  logic [4:0] IFID_Rs,
  input  logic [4:0] IFID_Rt,
  input  logic       IDEX_MemRead,
  input  logic [4:0] IDEX_Rt,
  input  logic       BranchTaken,
  output logic       PCWrite,
  output logic       IFID_Enable,
  output logic       HazardMuxSelect,
  output logic       IF_Flush,
  output logic       MulBusy
);

  stall_state_t      state_d;
  stall_state_t      state_q;
  logic              ld_use;
  logic              is_mul;
  logic              is_mfhilo;
  logic              mul_hz;
  logic              mul_issue;
  logic              mul_busy;
  logic              stall;
  logic [MCNT_W-1:0] mcnt;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign ld_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                  ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));

  assign is_mul    = (IFID_OpCode == OP_RTYPE) &&
                     ((IFID_Funct == FN_MULT) || (IFID_Funct == FN_MULTU));
  assign is_mfhilo = (IFID_OpCode == OP_RTYPE) &&
                     ((IFID_Funct == FN_MFHI) || (IFID_Funct == FN_MFLO));

`ifdef MUL_INTERLOCK_EN
  mul_busy_counter #(
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mul_busy_counter (
    .clk   (clk),
    .rst   (Reset),
    .clear (LoadInstructions),
    .load  (mul_issue),
    .mcnt  (mcnt),
    .busy  (mul_busy)
  );

  // Both a following multiply and a Hi/Lo read must wait for the result.
  assign mul_hz    = mul_busy && (is_mul || is_mfhilo);
  assign mul_issue = is_mul && !stall;
`else
  logic unused_mul_inputs;

  assign mcnt              = '0;
  assign mul_busy          = 1'b0;
  assign mul_hz            = 1'b0;
  assign mul_issue         = 1'b0;
  assign unused_mul_inputs = ^{is_mul, is_mfhilo, MCNT_W'(MUL_LATENCY)};
`endif

  assign stall = LoadInstructions || ld_use || mul_hz;

  assign PCWrite         = !stall;
  assign IFID_Enable     = !stall;
  assign HazardMuxSelect = stall;
  // A branch stuck behind a stall flushes only when it actually advances.
  assign IF_Flush        = BranchTaken && !stall;
  assign MulBusy         = mul_busy;

  // MUL_WAIT mirrors "counter nonzero after this edge": stay while the count
  // is above one, since it decrements on the same edge.
  always_comb begin
    state_d = state_q;
    if (LoadInstructions) begin
      state_d = LOADING;
    end else if (mul_issue) begin
      state_d = MUL_WAIT;
    end else if ((state_q == MUL_WAIT) && (mcnt > MCNT_W'(1))) begin
      state_d = MUL_WAIT;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Hazard and stall controller for the 5-stage pipelined CPU. It sits in the ID stage and drives `PCWrite`, `IFID_Enable`, `HazardMuxSelect` and `IF_Flush`. It sequences the pipeline through:

- instruction-load mode;
- load-use bubbles;
- multi-cycle multiply interlocks on Hi/Lo;
- taken-branch flushes.

## Interface

Parameters:

- `MUL_LATENCY`, default 4: cycles a `mult`/`multu` occupies Hi/Lo after entering EX. Legal range 1..7.

Ports:

- `clk` in 1: the single clock; rising edge.
- `Reset` in 1: asynchronous, active-high. Clears all state.
- `LoadInstructions` in 1: instruction-memory load mode active.
- `IFID_OpCode` in 6: opcode of the instruction in IF/ID.
- `IFID_Funct` in 6: funct of the instruction in IF/ID.
- `IFID_Rs` in 5: rs field of the instruction in IF/ID.
- `IFID_Rt` in 5: rt field of the instruction in IF/ID.
- `IDEX_MemRead` in 1: the instruction in EX is a load.
- `IDEX_Rt` in 5: destination register of that load.
- `BranchTaken` in 1: ID branch/jump resolved as taken.
- `PCWrite` out 1: PC load enable.
- `IFID_Enable` out 1: IF/ID register enable.
- `HazardMuxSelect` out 1: 1 = zero the ID/EX control, Rs/Rt/Rd and immediate (bubble).
- `IF_Flush` out 1: clear IF/ID on the next edge.
- `MulBusy` out 1: multiply in flight (busy counter nonzero).

## Operation

- States: `RUN`, `LOADING`, `MUL_WAIT`. A 3-bit busy counter `mcnt` runs alongside.
- Condition signals:
  - `ld_use` = `IDEX_MemRead` and `IDEX_Rt`≠0 and (`IDEX_Rt`==`IFID_Rs` or `IDEX_Rt`==`IFID_Rt`).
  - `is_mul` = opcode 6'h00 with funct 6'h18 or 6'h19.
  - `is_mfhilo` = opcode 6'h00 with funct 6'h10 or 6'h12.
  - `mul_hz` = `mcnt`≠0 and (`is_mul` or `is_mfhilo`).
- `stall` = `LoadInstructions` or `ld_use` or `mul_hz`. When asserted: `PCWrite`=0, `IFID_Enable`=0, `HazardMuxSelect`=1.
- `IF_Flush` = `BranchTaken` and not `stall`. A branch sitting behind a stall flushes only on the cycle it actually advances.
- Priority: `LoadInstructions` > `ld_use` > `mul_hz` > branch.
- Multiply issue: on a non-stalled cycle with `is_mul` in ID, `mcnt` loads `MUL_LATENCY` at the edge and the state goes to `MUL_WAIT`.
- In `MUL_WAIT`, `mcnt` decrements by 1 each edge. When it reaches 0 the state returns to `RUN`.
- A second `mult` in ID while `mcnt`≠0 stalls and issues only after `mcnt` reaches 0.
- `LOADING`: entered from any state the edge after `LoadInstructions` rises. It forces `mcnt`=0 and exits to `RUN` the edge after `LoadInstructions` falls.
- `MulBusy` = (`mcnt`≠0).

## Timing

- All hazard outputs are combinational from the current inputs plus registered state. They respond in the same cycle, with zero latency.
- Reset values, with inputs idle: `PCWrite`=1, `IFID_Enable`=1, `HazardMuxSelect`=0, `IF_Flush`=0, `MulBusy`=0, state `RUN`, `mcnt`=0.
- A load-use hazard causes exactly one bubble: the load advances to MEM and forwarding covers the rest.
- A `mfhi`/`mflo` directly behind a `mult` stalls `MUL_LATENCY` cycles.
- `Reset` asserted mid-multiply or mid-load clears `mcnt` and state immediately, independent of `clk`.
- `mcnt` never wraps: decrementing stops at 0.

## Configuration

- `MUL_INTERLOCK_EN` defined: the multiply counter, `MUL_WAIT` state and `mul_hz` term are present.
- `MUL_INTERLOCK_EN` undefined: `mul_hz`=0, `MulBusy` tied 0, no `MUL_WAIT` state. The multiply is treated as single-cycle.

## Structure

- Shared package `cpu_pkg`:
  - opcode/funct constants (`OP_RTYPE`, `FN_MULT`, `FN_MULTU`, `FN_MFHI`, `FN_MFLO`);
  - the state enum `stall_state_t`.
- One sub-module, `mul_busy_counter`: load/decrement/zero-detect of `mcnt`, parameterised by `MUL_LATENCY`.

## Test plan

- Reset, idle inputs -> `PCWrite`=1, `IFID_Enable`=1, `HazardMuxSelect`=0, `IF_Flush`=0, `MulBusy`=0.
- `IDEX_MemRead`=1, `IDEX_Rt`=5, `IFID_Rs`=5 -> one cycle with `PCWrite`=0, `HazardMuxSelect`=1. The same case with `IDEX_Rt`=0 -> no stall.
- `mult` in ID, then `mflo`, with `MUL_LATENCY`=4 -> `MulBusy` high 4 cycles and `mflo` held 4 cycles. `PCWrite` returns to 1 when `mcnt`=0.
- `BranchTaken`=1 with no hazard -> `IF_Flush`=1. `BranchTaken`=1 together with `ld_use` -> `IF_Flush`=0 that cycle and 1 the next.
- `LoadInstructions` high for 10 cycles during `MUL_WAIT` -> stall all 10 cycles, `mcnt` cleared, `RUN` one edge after the fall.
- `Reset` pulsed between clock edges while `mcnt`=3 -> `MulBusy`=0 immediately.
